// File: rtl/ram_access_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | ram_access_arbiter_pkg : shared sizes, FSM state codes and port IDs         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package ram_access_arbiter_pkg;

  localparam int RAM_ADLINES   = 8;
  localparam int RAM_DATALINES = 16;
  localparam int RAM_SIZE      = 256;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] size);
    return addr < size;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_access_arbiter_rr_arbiter2.sv
// +----------------------------------------------------------------------------+
// | rr_arbiter2 : two-way round-robin grant with a favour pointer               |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter2
  import ram_access_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant_valid,
  output logic       grant_port
);

  logic pointer;

  always_comb begin
    grant_valid = |req;
    if (&req)
      grant_port = pointer;
    else if (req[1])
      grant_port = PORT_B;
    else
      grant_port = PORT_A;
  end

  // After every grant the pointer favours the port that did not win.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pointer <= PORT_A;
    else if (advance && grant_valid)
      pointer <= ~grant_port;
  end

endmodule

`default_nettype wire

// File: rtl/ram_access_arbiter.sv
// +----------------------------------------------------------------------------+
// | ram_access_arbiter : shares one async level-strobed RAM between two ports   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int ADLINES   = RAM_ADLINES,
  parameter int DATALINES = RAM_DATALINES,
  parameter int RAMSIZE   = RAM_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADLINES-1:0]   a_addr,
  input  logic [DATALINES-1:0] a_wdata,
  output logic [DATALINES-1:0] a_rdata,
  output logic                 a_ack,
  output logic                 a_err,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADLINES-1:0]   b_addr,
  input  logic [DATALINES-1:0] b_wdata,
  output logic [DATALINES-1:0] b_rdata,
  output logic                 b_ack,
  output logic                 b_err,
  output logic [ADLINES-1:0]   ram_address,
  output logic [DATALINES-1:0] ram_datain,
  input  logic [DATALINES-1:0] ram_dataout,
  output logic                 ram_read,
  output logic                 ram_write,
  output logic                 busy
);

  logic [1:0]           state;
  logic                 cur_port;
  logic                 cur_we;
  logic                 cur_ok;
  logic                 grant_valid;
  logic                 grant_port;
  logic                 advance;
  logic                 sel_we;
  logic [ADLINES-1:0]   sel_addr;
  logic [DATALINES-1:0] sel_wdata;

  assign advance = (state == ST_IDLE);

  rr_arbiter2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         ({b_req, a_req}),
    .advance     (advance),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  always_comb begin
    if (grant_port == PORT_B) begin
      sel_we    = b_we;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end else begin
      sel_we    = a_we;
      sel_addr  = a_addr;
      sel_wdata = a_wdata;
    end
  end

  // ram_address and ram_datain double as the request latches, so they stay
  // put from SETUP through DONE without a separate copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cur_port    <= PORT_A;
      cur_we      <= 1'b0;
      cur_ok      <= 1'b0;
      ram_address <= '0;
      ram_datain  <= '0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      busy        <= 1'b0;
      a_rdata     <= '0;
      a_ack       <= 1'b0;
      a_err       <= 1'b0;
      b_rdata     <= '0;
      b_ack       <= 1'b0;
      b_err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state       <= ST_SETUP;
            busy        <= 1'b1;
            cur_port    <= grant_port;
            cur_we      <= sel_we;
            cur_ok      <= addr_in_range(32'(sel_addr), 32'(RAMSIZE));
            ram_address <= sel_addr;
            ram_datain  <= sel_we ? sel_wdata : '0;
          end
        end
        ST_SETUP: begin
          state     <= ST_STROBE;
          ram_read  <= cur_ok & ~cur_we;
          ram_write <= cur_ok & cur_we;
        end
        ST_STROBE: begin
          state     <= ST_DONE;
          ram_read  <= 1'b0;
          ram_write <= 1'b0;
          if (cur_port == PORT_A) begin
            a_ack <= 1'b1;
            a_err <= ~cur_ok;
            if (cur_ok && !cur_we)
              a_rdata <= ram_dataout;
          end else begin
            b_ack <= 1'b1;
            b_err <= ~cur_ok;
            if (cur_ok && !cur_we)
              b_rdata <= ram_dataout;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          a_ack <= 1'b0;
          a_err <= 1'b0;
          b_ack <= 1'b0;
          b_err <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
